// File: rtl/regfile_arb_pkg.sv
// Shared defaults, zero-register index and FSM state type for the register-file
// write-port arbiter.
package regfile_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int ADDR_W_DEF    = 5;
    localparam int DATA_W_DEF    = 64;
    localparam int MAX_BURST_DEF = 4;
    localparam int ZERO_REG      = 31;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_priority.sv
// Combinational round-robin search: one-hot pick of the first requester at or
// after rr_ptr, wrapping modulo NREQ.
module rr_priority
    import regfile_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick
);

    logic w_found;

    // Scan upward from rr_ptr and keep only the first hit.
    always_comb begin
        pick    = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!w_found && req[idx]) begin
                pick[idx] = 1'b1;
                w_found   = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NREQ requesters onto a single register-file write port with
// round-robin fairness and bounded locked bursts.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               lock,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]               grant,
    output logic                          RegWrite,
    output logic [ADDR_W-1:0]             WriteRegister,
    output logic [DATA_W-1:0]             WriteData
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    arb_state_e        r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [BC_W-1:0]   r_burst_cnt;

    logic [NREQ-1:0]   w_pick;
    logic [NREQ-1:0]   w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [IDX_W-1:0]  w_owner_next;
    logic [BC_W-1:0]   w_burst_inc;
    logic              w_xfer;
    logic              w_zero_dst;

    rr_priority #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_priority (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .pick   (w_pick)
    );

    // Grant: round-robin pick when free, only the owner while a burst is held.
    always_comb begin
        w_grant = '0;
        if (reset) begin
            w_grant = '0;
        end else if (r_state == ST_IDLE) begin
            w_grant = w_pick;
        end else if (req[r_owner]) begin
            w_grant[r_owner] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    // Binary index of the (one-hot) granted requester.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_idx = w_idx | IDX_W'(i);
            end else begin
                w_idx = w_idx;
            end
        end
    end

    assign grant        = w_grant;
    assign w_xfer       = |w_grant;
    assign w_zero_dst   = (req_addr[w_idx] == ADDR_W'(ZERO_REG));
    assign w_idx_next   = (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + IDX_W'(1);
    assign w_owner_next = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_burst_inc  = r_burst_cnt + BC_W'(1);

    // Write-port outputs and ownership FSM; writes to the zero register are
    // accepted but never reach the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_burst_cnt   <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= w_xfer && !w_zero_dst;
            if (w_xfer && !w_zero_dst) begin
                WriteRegister <= req_addr[w_idx];
                WriteData     <= req_data[w_idx];
            end else begin
                WriteRegister <= WriteRegister;
                WriteData     <= WriteData;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_rr_ptr <= w_idx_next;
                        if (lock[w_idx] && (MAX_BURST > 1)) begin
                            r_state     <= ST_OWNED;
                            r_owner     <= w_idx;
                            r_burst_cnt <= BC_W'(1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (!req[r_owner] || !lock[r_owner] ||
                        (w_burst_inc == BC_W'(MAX_BURST))) begin
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= '0;
                        r_rr_ptr    <= w_owner_next;
                    end else begin
                        r_burst_cnt <= w_burst_inc;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued when a
// grant is expected and compared when the registered write appears.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NREQ-1:0]             req;
    logic [NREQ-1:0]             lock;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_data;
    logic [NREQ-1:0]             grant;
    logic                        RegWrite;
    logic [ADDR_W-1:0]           WriteRegister;
    logic [DATA_W-1:0]           WriteData;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    regfile_write_arbiter #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .lock          (lock),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .grant         (grant),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic refresh_data();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = ADDR_W'(3 * i + 2);
            req_data[i] = {$urandom(), $urandom()};
        end
    endtask

    // Check grant before the edge, queue the expected write, then check the
    // registered write port one cycle later.
    task automatic cycle(input string tag, input logic [NREQ-1:0] exp_grant);
        wr_t e;
        #1;
        chk({tag, "/grant"}, {124'd0, grant}, {124'd0, exp_grant});
        for (int i = 0; i < NREQ; i++) begin
            if (exp_grant[i] && (req_addr[i] != ADDR_W'(ZERO_REG))) begin
                exp_q.push_back('{a: req_addr[i], d: req_data[i]});
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "/we"},   {127'd0, RegWrite},        128'd1);
            chk({tag, "/addr"}, {123'd0, WriteRegister},   {123'd0, e.a});
            chk({tag, "/data"}, {64'd0, WriteData},        {64'd0, e.d});
        end else begin
            chk({tag, "/we"},   {127'd0, RegWrite},        128'd0);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "/grant"}, {124'd0, grant},         128'd0);
        chk({tag, "/we"},    {127'd0, RegWrite},      128'd0);
        chk({tag, "/addr"},  {123'd0, WriteRegister}, 128'd0);
        chk({tag, "/data"},  {64'd0, WriteData},      128'd0);
    endtask

    initial begin
        logic [NREQ-1:0] rr_seq [5];
        logic [NREQ-1:0] burst_seq [6];
        rr_seq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        burst_seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};

        reset = 1'b1;
        req   = '0;
        lock  = '0;
        refresh_data();
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("in_reset");
        reset = 1'b0;

        // Idle after reset.
        #1;
        chk_zero_outputs("post_reset");
        cycle("idle", 4'b0000);

        // Plain round robin from rr_ptr 0, fresh data every cycle.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            refresh_data();
            cycle($sformatf("rr%0d", k), rr_seq[k]);
        end

        // rr_ptr is now 1: requester 2 locks for MAX_BURST, then 0, then 2 again.
        req  = 4'b0101;
        lock = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            refresh_data();
            cycle($sformatf("burst%0d", k), burst_seq[k]);
        end
        req  = '0;
        lock = '0;
        cycle("drain", 4'b0000);

        // Zero-register destination: granted but never written.
        req         = 4'b0010;
        req_addr[1] = ADDR_W'(ZERO_REG);
        req_data[1] = 64'hDEAD;
        cycle("zero_reg", 4'b0010);
        req = '0;
        refresh_data();

        // rr_ptr is 2: requester 3 locks, two transfers, then reset mid-burst.
        req  = 4'b1000;
        lock = 4'b1000;
        cycle("lock3_a", 4'b1000);
        cycle("lock3_b", 4'b1000);
        #1;
        chk("lock3_c/grant", {124'd0, grant}, {124'd0, 4'b1000});
        reset = 1'b1;
        #1;
        chk_zero_outputs("mid_reset");
        @(posedge clk);
        #1;
        chk_zero_outputs("reset_edge");
        reset = 1'b0;
        req   = 4'b1010;
        lock  = '0;
        #1;
        chk("after_reset/grant", {124'd0, grant}, {124'd0, 4'b0010});

        // Requester 1 owns, then drops lock while still requesting.
        req  = 4'b0110;
        lock = 4'b0010;
        cycle("own1", 4'b0010);
        lock = 4'b0000;
        cycle("own1_drop", 4'b0010);
        cycle("after_drop", 4'b0100);
        req = '0;
        cycle("final", 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
